// File: rtl/mrv32_run_monitor.sv
// -----------------------------------------------------------------------------
// mrv32_run_monitor
//
// Watches a single-issue RV32 core while it runs a program. It decides when the
// run is over (watchdog timeout, unsupported instruction, or the core parked in
// a self-jump), keeps run statistics, and records the PCs of retired
// instructions in a small circular trace buffer that software drains later.
//
// Ports
//   clk                 rising-edge clock for all logic
//   rst                 synchronous, active-high reset
//   start               leave IDLE and begin monitoring (ignored elsewhere)
//   retire_valid        one instruction retires this cycle
//   retire_pc           PC of the retiring instruction
//   retire_next_pc      PC the core continues from after it
//   stall               core pipeline stall
//   unsupported_instr   core illegal-instruction flag
//   trace_rd_en         pop the oldest trace entry
//   running / done      registered decode of RUN / HALTED
//   done_cause          0 none, 1 timeout, 2 unsupported, 3 self-loop
//   cycle_count         RUN cycles (saturating)
//   retire_count        RUN cycles with a retirement (saturating)
//   stall_count         RUN cycles with a stall (saturating)
//   trace_pc            oldest trace entry (don't-care while trace_valid = 0)
//   trace_valid         trace buffer non-empty
//   trace_level         trace buffer occupancy
//   trace_overflow      sticky: an entry was overwritten before being read
// -----------------------------------------------------------------------------
module mrv32_run_monitor #(
  parameter int ADDR_WIDTH  = 32,
  parameter int MAX_CYCLES  = 500,
  parameter int TRACE_DEPTH = 16,
  parameter int LOOP_LIMIT  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          retire_valid,
  input  logic [ADDR_WIDTH-1:0]         retire_pc,
  input  logic [ADDR_WIDTH-1:0]         retire_next_pc,
  input  logic                          stall,
  input  logic                          unsupported_instr,
  input  logic                          trace_rd_en,
  output logic                          running,
  output logic                          done,
  output logic [1:0]                    done_cause,
  output logic [31:0]                   cycle_count,
  output logic [31:0]                   retire_count,
  output logic [31:0]                   stall_count,
  output logic [ADDR_WIDTH-1:0]         trace_pc,
  output logic                          trace_valid,
  output logic [$clog2(TRACE_DEPTH):0]  trace_level,
  output logic                          trace_overflow
);

  localparam int PW   = $clog2(TRACE_DEPTH);
  localparam int LVW  = PW + 1;
  localparam int LW   = $clog2(LOOP_LIMIT + 1);
  localparam int NCNT = 3;

  localparam logic [31:0]    CNT_MAX    = 32'hFFFF_FFFF;
  localparam logic [31:0]    TIMEOUT_AT = 32'(MAX_CYCLES - 1);
  localparam logic [LW-1:0]  LOOP_LAST  = LW'(LOOP_LIMIT - 1);
  localparam logic [LW-1:0]  LOOP_MAX   = LW'(LOOP_LIMIT);
  localparam logic [LVW-1:0] LEVEL_FULL = LVW'(TRACE_DEPTH);

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'd1;
  localparam logic [1:0] CAUSE_UNSUP   = 2'd2;
  localparam logic [1:0] CAUSE_LOOP    = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [1:0]  cause_reg, cause_next;
  logic        running_reg, done_reg;
  logic [LW-1:0] loop_cnt_reg;

  logic in_run;
  logic self_jump;
  logic unsup_hit, loop_hit, timeout_hit;

  logic [NCNT-1:0]       cnt_en;
  logic [NCNT-1:0][31:0] cnt_val;

  assign in_run    = (state_reg == RUN);
  assign self_jump = retire_valid && (retire_pc == retire_next_pc);

  // Halt conditions are only meaningful while running. The self-loop fires on
  // the retirement that would bring the counter up to LOOP_LIMIT; the timeout
  // fires on the RUN cycle whose pre-increment count is MAX_CYCLES-1.
  assign unsup_hit   = in_run && unsupported_instr;
  assign loop_hit    = in_run && self_jump && (loop_cnt_reg == LOOP_LAST);
  assign timeout_hit = in_run && (cnt_val[0] == TIMEOUT_AT);

  // ---------------------------------------------------------------------------
  // Run-control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cause_reg   <= CAUSE_NONE;
      running_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cause_reg   <= cause_next;
      running_reg <= (state_next == RUN);
      done_reg    <= (state_next == HALTED);
    end
  end

  always_comb begin
    state_next = state_reg;
    cause_next = cause_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        if (unsup_hit || loop_hit || timeout_hit) begin
          state_next = HALTED;
          if (unsup_hit)     cause_next = CAUSE_UNSUP;
          else if (loop_hit) cause_next = CAUSE_LOOP;
          else               cause_next = CAUSE_TIMEOUT;
        end
      end
      HALTED: begin
        state_next = HALTED;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign running    = running_reg;
  assign done       = done_reg;
  assign done_cause = cause_reg;

  // ---------------------------------------------------------------------------
  // Self-loop detector: counts back-to-back self-jump retirements. Cycles
  // without a retirement (stalls, bubbles) leave it untouched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      loop_cnt_reg <= '0;
    end else if (in_run && retire_valid) begin
      if (!self_jump)
        loop_cnt_reg <= '0;
      else if (loop_cnt_reg != LOOP_MAX)
        loop_cnt_reg <= loop_cnt_reg + LW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Statistics counters: 0 = cycles, 1 = retirements, 2 = stalls.
  // All count only in RUN and stick at all-ones.
  // ---------------------------------------------------------------------------
  assign cnt_en = {in_run && stall, in_run && retire_valid, in_run};

  generate
    for (genvar gi = 0; gi < NCNT; gi++) begin : g_cnt
      logic [31:0] count_reg;

      always_ff @(posedge clk) begin
        if (rst)
          count_reg <= '0;
        else if (cnt_en[gi] && (count_reg != CNT_MAX))
          count_reg <= count_reg + 32'd1;
      end

      assign cnt_val[gi] = count_reg;
    end
  endgenerate

  assign cycle_count  = cnt_val[0];
  assign retire_count = cnt_val[1];
  assign stall_count  = cnt_val[2];

  // ---------------------------------------------------------------------------
  // Trace buffer
  // A full buffer receiving a push without a pop drops its oldest entry: the
  // write lands on the head slot and the head moves on, so occupancy stays at
  // TRACE_DEPTH. A simultaneous pop frees that slot first, so nothing is lost.
  // ---------------------------------------------------------------------------
  logic [ADDR_WIDTH-1:0] trace_mem [TRACE_DEPTH];
  logic [PW-1:0]         head_reg, tail_reg;
  logic [LVW-1:0]        level_reg;
  logic                  overflow_reg;

  logic push, do_pop, buf_empty, buf_full;

  assign buf_empty = (level_reg == '0);
  assign buf_full  = (level_reg == LEVEL_FULL);
  assign push      = in_run && retire_valid;
  assign do_pop    = trace_rd_en && !buf_empty;

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (!rst && push)
      trace_mem[tail_reg] <= retire_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg     <= '0;
      tail_reg     <= '0;
      level_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push)
        tail_reg <= tail_reg + PW'(1);

      if (do_pop || (push && buf_full))
        head_reg <= head_reg + PW'(1);

      if (push && !do_pop && !buf_full)
        level_reg <= level_reg + LVW'(1);
      else if (do_pop && !push)
        level_reg <= level_reg - LVW'(1);

      if (push && buf_full && !do_pop)
        overflow_reg <= 1'b1;
    end
  end

  assign trace_pc       = trace_mem[head_reg];
  assign trace_valid    = !buf_empty;
  assign trace_level    = level_reg;
  assign trace_overflow = overflow_reg;

endmodule

// File: tb/tb_mrv32_run_monitor.sv
// -----------------------------------------------------------------------------
// tb_mrv32_run_monitor
//
// Self-checking bench for mrv32_run_monitor with MAX_CYCLES=20, TRACE_DEPTH=4,
// LOOP_LIMIT=4. Directed scenarios check the documented cases against literal
// values; a randomized phase checks every output every cycle against a
// behavioural model built on integers and a queue.
// -----------------------------------------------------------------------------
module tb_mrv32_run_monitor;

  localparam int AW    = 32;
  localparam int MAXC  = 20;
  localparam int DEPTH = 4;
  localparam int LOOPL = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          retire_valid;
  logic [AW-1:0] retire_pc;
  logic [AW-1:0] retire_next_pc;
  logic          stall;
  logic          unsupported_instr;
  logic          trace_rd_en;
  logic          running;
  logic          done;
  logic [1:0]    done_cause;
  logic [31:0]   cycle_count;
  logic [31:0]   retire_count;
  logic [31:0]   stall_count;
  logic [AW-1:0] trace_pc;
  logic          trace_valid;
  logic [2:0]    trace_level;
  logic          trace_overflow;

  int checks = 0;
  int passes = 0;

  mrv32_run_monitor #(
    .ADDR_WIDTH (AW),
    .MAX_CYCLES (MAXC),
    .TRACE_DEPTH(DEPTH),
    .LOOP_LIMIT (LOOPL)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .retire_valid     (retire_valid),
    .retire_pc        (retire_pc),
    .retire_next_pc   (retire_next_pc),
    .stall            (stall),
    .unsupported_instr(unsupported_instr),
    .trace_rd_en      (trace_rd_en),
    .running          (running),
    .done             (done),
    .done_cause       (done_cause),
    .cycle_count      (cycle_count),
    .retire_count     (retire_count),
    .stall_count      (stall_count),
    .trace_pc         (trace_pc),
    .trace_valid      (trace_valid),
    .trace_level      (trace_level),
    .trace_overflow   (trace_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Behavioural reference model
  // ---------------------------------------------------------------------------
  int          m_state;   // 0 idle, 1 run, 2 halted
  logic [31:0] m_cyc, m_ret, m_stl;
  int          m_loop;
  int          m_cause;
  logic [31:0] m_q[$];
  bit          m_ovf;

  task automatic model_step();
    bit is_run, unsup, selfhit, tmo, sj;
    if (rst) begin
      m_state = 0; m_cyc = 0; m_ret = 0; m_stl = 0;
      m_loop = 0; m_cause = 0; m_ovf = 0;
      m_q.delete();
      return;
    end
    is_run = (m_state == 1);
    // trace: pop first, then append; a full buffer without a pop drops its oldest
    if (trace_rd_en && m_q.size() > 0) void'(m_q.pop_front());
    if (is_run && retire_valid) begin
      if (m_q.size() == DEPTH) begin
        void'(m_q.pop_front());
        m_ovf = 1;
      end
      m_q.push_back(retire_pc);
    end
    if (m_state == 0) begin
      if (start) m_state = 1;
    end else if (is_run) begin
      sj      = retire_valid && (retire_pc == retire_next_pc);
      unsup   = unsupported_instr;
      selfhit = sj && (m_loop + 1 == LOOPL);
      tmo     = (m_cyc == 32'(MAXC - 1));
      if (retire_valid) m_loop = sj ? m_loop + 1 : 0;
      if (m_cyc != 32'hFFFF_FFFF) m_cyc = m_cyc + 1;
      if (retire_valid && m_ret != 32'hFFFF_FFFF) m_ret = m_ret + 1;
      if (stall && m_stl != 32'hFFFF_FFFF) m_stl = m_stl + 1;
      if (unsup)        begin m_state = 2; m_cause = 2; end
      else if (selfhit) begin m_state = 2; m_cause = 3; end
      else if (tmo)     begin m_state = 2; m_cause = 1; end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; retire_valid = 0; retire_pc = '0; retire_next_pc = '0;
    stall = 0; unsupported_instr = 0; trace_rd_en = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic do_start();
    start = 1;
    tick();
    start = 0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    // reset asserted together with start, a retirement and a pop
    idle_inputs();
    rst = 1; start = 1; retire_valid = 1; retire_pc = 32'h10; retire_next_pc = 32'h14;
    trace_rd_en = 1;
    tick();
    tick();
    idle_inputs();
    rst = 0;
    checks++;
    if ({running, done, done_cause} !== 4'b0000)
      $display("FAIL reset_state: running/done/cause=%b required 0000", {running, done, done_cause});
    else passes++;
    checks++;
    if ({cycle_count, retire_count, stall_count} !== 96'd0)
      $display("FAIL reset_counts: cyc=%0d ret=%0d stl=%0d required 0", cycle_count, retire_count, stall_count);
    else passes++;
    checks++;
    if ({trace_valid, trace_level, trace_overflow} !== 5'b0)
      $display("FAIL reset_trace: valid=%b level=%0d ovf=%b required 0/0/0", trace_valid, trace_level, trace_overflow);
    else passes++;
    $display("test_reset done");
  endtask

  task automatic test_timeout();
    int n;
    do_reset();
    do_start();
    checks++;
    if (running !== 1'b1) $display("FAIL timeout_running: running=%b required 1", running);
    else passes++;
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== MAXC) $display("FAIL timeout_cycles: halted after %0d RUN cycles required %0d", n, MAXC);
    else passes++;
    checks++;
    if ({done, running, done_cause} !== 4'b1001)
      $display("FAIL timeout_cause: done=%b running=%b cause=%0d required 1/0/1", done, running, done_cause);
    else passes++;
    checks++;
    if (cycle_count !== 32'd20) $display("FAIL timeout_count: cycle_count=%0d required 20", cycle_count);
    else passes++;
    $display("test_timeout: halted after %0d RUN cycles, cause %0d", n, done_cause);
  endtask

  task automatic test_self_loop();
    logic [31:0] pcs  [8];
    logic [31:0] nxts [8];
    for (int i = 0; i < 8; i++) begin pcs[i] = 32'h40; nxts[i] = 32'h40; end
    pcs[3] = 32'h44; nxts[3] = 32'h48;
    do_reset();
    do_start();
    for (int i = 0; i < 8; i++) begin
      retire_valid = 1; retire_pc = pcs[i]; retire_next_pc = nxts[i];
      tick();
      checks++;
      if (done !== (i == 7)) $display("FAIL self_loop_done_%0d: done=%b required %b", i, done, (i == 7));
      else passes++;
      $display("retire pc=%h next=%h done=%b", pcs[i], nxts[i], done);
    end
    idle_inputs();
    checks++;
    if (done_cause !== 2'd3) $display("FAIL self_loop_cause: cause=%0d required 3", done_cause);
    else passes++;
    checks++;
    if (retire_count !== 32'd8) $display("FAIL self_loop_retires: retire_count=%0d required 8", retire_count);
    else passes++;
  endtask

  task automatic test_priority();
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) begin
      retire_valid = 1; retire_pc = 32'h80; retire_next_pc = 32'h80;
      unsupported_instr = (i == 3);
      tick();
    end
    idle_inputs();
    checks++;
    if ({done, done_cause} !== 3'b110) $display("FAIL priority_cause: done=%b cause=%0d required 1/2", done, done_cause);
    else passes++;
    for (int i = 0; i < 25; i++) tick();
    checks++;
    if (done_cause !== 2'd2) $display("FAIL priority_held: cause=%0d required 2", done_cause);
    else passes++;
    checks++;
    if (cycle_count !== 32'd4) $display("FAIL priority_frozen: cycle_count=%0d required 4", cycle_count);
    else passes++;
    $display("test_priority: cause %0d after 25 extra cycles", done_cause);
  endtask

  task automatic test_trace_wrap();
    do_reset();
    do_start();
    for (int i = 0; i < 6; i++) begin
      retire_valid = 1; retire_pc = 32'(4 * i); retire_next_pc = 32'(4 * i + 4);
      tick();
    end
    idle_inputs();
    checks++;
    if ({trace_overflow, trace_level} !== {1'b1, 3'd4})
      $display("FAIL wrap_level: ovf=%b level=%0d required 1/4", trace_overflow, trace_level);
    else passes++;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (trace_valid !== 1'b1 || trace_pc !== 32'(8 + 4 * k))
        $display("FAIL wrap_pop_%0d: valid=%b pc=%h required 1/%h", k, trace_valid, trace_pc, 32'(8 + 4 * k));
      else passes++;
      $display("pop pc=%h", trace_pc);
      trace_rd_en = 1;
      tick();
      trace_rd_en = 0;
    end
    checks++;
    if (trace_valid !== 1'b0) $display("FAIL wrap_empty: trace_valid=%b required 0", trace_valid);
    else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) begin
      retire_valid = 1; retire_pc = 32'h100 + 32'(4 * i); retire_next_pc = retire_pc + 4;
      tick();
    end
    checks++;
    if ({trace_overflow, trace_level} !== {1'b0, 3'd4})
      $display("FAIL b2b_fill: ovf=%b level=%0d required 0/4", trace_overflow, trace_level);
    else passes++;
    for (int i = 0; i < 10; i++) begin
      exp_pc = (i < 4) ? 32'h100 + 32'(4 * i) : 32'h200 + 32'(4 * (i - 4));
      checks++;
      if (trace_pc !== exp_pc) $display("FAIL b2b_order_%0d: pc=%h required %h", i, trace_pc, exp_pc);
      else passes++;
      $display("push %h pop %h", 32'h200 + 32'(4 * i), trace_pc);
      retire_valid = 1; retire_pc = 32'h200 + 32'(4 * i); retire_next_pc = retire_pc + 4;
      trace_rd_en = 1;
      tick();
      checks++;
      if ({trace_overflow, trace_level} !== {1'b0, 3'd4})
        $display("FAIL b2b_level_%0d: ovf=%b level=%0d required 0/4", i, trace_overflow, trace_level);
      else passes++;
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    do_start();
    for (int i = 0; i < 7; i++) begin
      stall = 1; retire_valid = (i % 2 == 0);
      retire_pc = 32'h500 + 32'(4 * i); retire_next_pc = retire_pc + 4;
      tick();
    end
    idle_inputs();
    checks++;
    if (stall_count !== 32'd7) $display("FAIL midrun_stalls: stall_count=%0d required 7", stall_count);
    else passes++;
    rst = 1; start = 1; retire_valid = 1; retire_pc = 32'h600; retire_next_pc = 32'h604;
    tick();
    idle_inputs();
    rst = 0;
    checks++;
    if ({running, done, done_cause, cycle_count, retire_count, stall_count, trace_valid, trace_level} !== '0)
      $display("FAIL midrun_reset: run=%b done=%b cyc=%0d ret=%0d stl=%0d valid=%b required all 0",
               running, done, cycle_count, retire_count, stall_count, trace_valid);
    else passes++;
    do_start();
    for (int i = 0; i < 3; i++) begin
      retire_valid = 1; retire_pc = 32'h300 + 32'(4 * i); retire_next_pc = retire_pc + 4;
      tick();
    end
    idle_inputs();
    checks++;
    if ({running, cycle_count, retire_count, trace_level, trace_pc} !== {1'b1, 32'd3, 32'd3, 3'd3, 32'h300})
      $display("FAIL midrun_restart: run=%b cyc=%0d ret=%0d level=%0d pc=%h required 1/3/3/3/300",
               running, cycle_count, retire_count, trace_level, trace_pc);
    else passes++;
    $display("test_reset_mid_run: restart retire_count=%0d", retire_count);
  endtask

  task automatic test_random();
    logic [104:0] obs, exp;
    int errs;
    errs = 0;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst               = ($urandom_range(0, 63) == 0);
      start             = ($urandom_range(0, 3) == 0);
      retire_valid      = $urandom_range(0, 1);
      retire_pc         = 32'($urandom_range(0, 3) * 4);
      retire_next_pc    = ($urandom_range(0, 1) == 1) ? retire_pc : retire_pc + 4;
      stall             = ($urandom_range(0, 2) == 0);
      unsupported_instr = ($urandom_range(0, 49) == 0);
      trace_rd_en       = ($urandom_range(0, 2) == 0);
      tick();
      obs = {running, done, done_cause, cycle_count, retire_count, stall_count,
             trace_valid, trace_level, trace_overflow};
      exp = {m_state == 1, m_state == 2, 2'(m_cause), m_cyc, m_ret, m_stl,
             m_q.size() != 0, 3'(m_q.size()), m_ovf};
      checks++;
      if (obs !== exp) begin
        $display("FAIL random_status_%0d: got %h required %h", c, obs, exp);
        errs++;
      end else passes++;
      if (m_q.size() != 0) begin
        checks++;
        if (trace_pc !== m_q[0]) begin
          $display("FAIL random_trace_pc_%0d: got %h required %h", c, trace_pc, m_q[0]);
          errs++;
        end else passes++;
      end
    end
    idle_inputs();
    rst = 0;
    $display("test_random: 600 cycles, %0d discrepancies", errs);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 0;
    idle_inputs();
    @(posedge clk);
    #1;
    test_reset();
    test_timeout();
    test_self_loop();
    test_priority();
    test_trace_wrap();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
